// File: rtl/oserdes_seq_pkg.sv
// Shared types and defaults for the OSERDESE3 transmit sequencer.
package oserdes_seq_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_IDLE  = 2'd1,
    S_TRAIN = 2'd2,
    S_RUN   = 2'd3
  } seq_state_e;

  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'h5A;
  localparam logic [7:0] IDLE_PATTERN_DEF  = 8'h00;

  // DDR output: two bits leave the serializer per fast-clock cycle.
  function automatic int unsigned div_of(input int unsigned data_width);
    return data_width / 2;
  endfunction

endpackage

// File: rtl/oserdes_clkdiv_gen.sv
// Fast-clock phase counter producing the word tick and a 50% duty CLKDIV.
module oserdes_clkdiv_gen #(
  parameter int unsigned DIV = 4,
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] ph,
  output logic          clk_div,
  output logic          tick
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);

  logic [PW-1:0] ph_nxt;

  assign tick   = (ph == LAST);
  assign ph_nxt = tick ? '0 : ph + 1'b1;

  // clk_div is derived from the next phase so it stays aligned with ph.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph      <= '0;
      clk_div <= 1'b1;
    end else begin
      ph      <= ph_nxt;
      clk_div <= (ph_nxt < HALF);
    end
  end

endmodule

// File: rtl/oserdes_tx_sequencer.sv
// Reset/train/run sequencer feeding one OSERDESE3 from its fast clock domain.
module oserdes_tx_sequencer
  import oserdes_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RST_WORDS     = 4,
  parameter int unsigned TRAIN_WORDS   = 16,
  parameter logic [7:0]  TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter logic [7:0]  IDLE_PATTERN  = IDLE_PATTERN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  clk_div,
  output logic                  serdes_rst,
  output logic [DATA_WIDTH-1:0] serdes_d,
  output logic                  serdes_t,
  output logic [1:0]            state_o,
  output logic [15:0]           underrun_cnt
);

  localparam int unsigned DIV = div_of(DATA_WIDTH);
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DATA_WIDTH-1:0] TRAIN_W    = TRAIN_PATTERN[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] IDLE_W     = IDLE_PATTERN[DATA_WIDTH-1:0];
  localparam logic [7:0]            RST_LAST   = 8'(RST_WORDS - 1);
  localparam logic [7:0]            TRAIN_LAST = 8'(TRAIN_WORDS - 1);

  if (DATA_WIDTH != 4 && DATA_WIDTH != 8) begin : g_bad_width
    $error("oserdes_tx_sequencer: DATA_WIDTH must be 4 or 8");
  end
  if (RST_WORDS < 1 || RST_WORDS > 255 || TRAIN_WORDS < 1 || TRAIN_WORDS > 255) begin : g_bad_count
    $error("oserdes_tx_sequencer: RST_WORDS/TRAIN_WORDS must be 1..255");
  end

  seq_state_e    state;
  logic [7:0]    wcnt;
  logic [PW-1:0] ph;
  logic          tick;

  oserdes_clkdiv_gen #(.DIV(DIV)) u_clkdiv (
    .clk     (clk),
    .rst     (rst),
    .ph      (ph),
    .clk_div (clk_div),
    .tick    (tick)
  );

  // Handshake only on the RUN tick that will really take the word.
  assign s_ready = (state == S_RUN) && tick && en && !rst;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RST;
      wcnt         <= '0;
      serdes_rst   <= 1'b1;
      serdes_t     <= 1'b1;
      serdes_d     <= IDLE_W;
      underrun_cnt <= '0;
    end else if (tick) begin
      case (state)
        S_RST: begin
          if (wcnt == RST_LAST) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            serdes_rst <= 1'b0;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_IDLE: begin
          if (en) begin
            state    <= S_TRAIN;
            wcnt     <= '0;
            serdes_d <= TRAIN_W;
            serdes_t <= 1'b0;
          end
        end
        S_TRAIN: begin
          if (wcnt == TRAIN_LAST) begin
            state    <= S_RUN;
            wcnt     <= '0;
            serdes_d <= IDLE_W;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_RUN: begin
          if (!en) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            serdes_t <= 1'b1;
            serdes_d <= IDLE_W;
          end else if (s_valid) begin
            serdes_d <= s_data;
          end else begin
            serdes_d <= IDLE_W;
            if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_oserdes_tx_sequencer.sv
// Directed bench for oserdes_tx_sequencer (DATA_WIDTH=8, RST_WORDS=4, TRAIN_WORDS=2).
module tb_oserdes_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        clk_div;
  logic        serdes_rst;
  logic [7:0]  serdes_d;
  logic        serdes_t;
  logic [1:0]  state_o;
  logic [15:0] underrun_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  oserdes_tx_sequencer #(
    .DATA_WIDTH  (8),
    .RST_WORDS   (4),
    .TRAIN_WORDS (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .clk_div      (clk_div),
    .serdes_rst   (serdes_rst),
    .serdes_d     (serdes_d),
    .serdes_t     (serdes_t),
    .state_o      (state_o),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // Advance one fast clock; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clkdiv", clk_div, 1);
    check("rst_serdes_rst", serdes_rst, 1);
    check("rst_t", serdes_t, 1);
    check("rst_d", serdes_d, 8'h00);
    check("rst_state", state_o, 0);
    check("rst_ready", s_ready, 0);
    check("rst_underrun", underrun_cnt, 0);

    // cycle 0: first cycle with rst low
    rst = 1'b0; en = 1'b1; cyc = 0;
    while (cyc < 36) begin
      check("a_clkdiv", clk_div, (cyc % 4) < 2);
      check("a_serdes_rst", serdes_rst, cyc < 16);
      check("a_t", serdes_t, cyc < 20);
      check("a_d", serdes_d, (cyc >= 20 && cyc < 28) ? 8'h5A : 8'h00);
      check("a_state", state_o, cyc < 16 ? 0 : cyc < 20 ? 1 : cyc < 28 ? 2 : 3);
      check("a_ready", s_ready, cyc >= 28 && (cyc % 4) == 3);
      check("a_underrun", underrun_cnt, cyc >= 32 ? (cyc - 28) / 4 : 0);
      step();
    end

    // streaming: 01,02,03 on consecutive words
    s_valid = 1'b1; s_data = 8'h01;
    while (cyc < 48) begin
      check("b_ready", s_ready, (cyc % 4) == 3);
      if ((cyc % 4) == 3) begin
        step();
        check("b_d", serdes_d, s_data);
        s_data = s_data + 8'h01;
      end else begin
        step();
      end
    end
    check("b_underrun", underrun_cnt, 2);

    // drop en with s_valid held: no handshake, back to idle
    en = 1'b0;
    while (cyc < 51) step();
    check("c_ready_en0", s_ready, 0);
    step();
    check("c_t", serdes_t, 1);
    check("c_d", serdes_d, 8'h00);
    check("c_state", state_o, 1);
    en = 1'b1;
    while (cyc < 56) step();
    check("c_train_state", state_o, 2);
    check("c_train_d", serdes_d, 8'h5A);
    check("c_train_t", serdes_t, 0);
    while (cyc < 60) step();
    check("c_train2_state", state_o, 2);
    while (cyc < 64) step();
    check("c_run_state", state_o, 3);
    check("c_run_d", serdes_d, 8'h00);
    while (cyc < 68) step();
    check("c_run_word", serdes_d, 8'h04);
    check("c_underrun", underrun_cnt, 2);

    // one-cycle reset at ph=2 in RUN
    while (cyc < 70) step();
    rst = 1'b1;
    step();
    rst = 1'b0; s_valid = 1'b0; cyc = 0;
    check("d_clkdiv", clk_div, 1);
    check("d_ph", dut.u_clkdiv.ph, 0);
    check("d_serdes_rst", serdes_rst, 1);
    check("d_t", serdes_t, 1);
    check("d_underrun", underrun_cnt, 0);
    check("d_ready", s_ready, 0);
    check("d_state", state_o, 0);
    while (cyc < 15) step();
    check("d_serdes_rst_hold", serdes_rst, 1);
    step();
    check("d_serdes_rst_drop", serdes_rst, 0);

    // saturation: preload near the top, then keep underrunning
    while (cyc < 32) step();
    check("e_underrun_1", underrun_cnt, 1);
    force dut.underrun_cnt = 16'hFFFC;
    while (cyc < 40) step();
    release dut.underrun_cnt;
    while (cyc < 64) step();
    check("e_sat", underrun_cnt, 16'hFFFF);
    while (cyc < 72) step();
    check("e_sat_hold", underrun_cnt, 16'hFFFF);

    // rst on a RUN tick blocks the handshake
    s_valid = 1'b1;
    while (cyc < 75) step();
    check("f_ready_tick", s_ready, 1);
    rst = 1'b1;
    #1;
    check("f_ready_rst", s_ready, 0);
    step();
    rst = 1'b0;
    check("f_underrun_clr", underrun_cnt, 0);
    check("f_state", state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
